// File: rtl/array_search_pkg.sv
// Shared types for the array search block: search modes, FSM states and
// a width helper used to size array/index buses.
package array_search_pkg;

   typedef enum logic [1:0] {
      MODE_INDEX   = 2'd0,
      MODE_LESS    = 2'd1,
      MODE_GREATER = 2'd2,
      MODE_EQUAL   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/array_search_if.sv
// Write/clear and search request/response signals of array_search.
// The master drives requests and writes; the slave is the search block.
interface array_search_if #(
   parameter int W  = 12,
   parameter int AW = 1,
   parameter int IW = 2
);
   logic          wrEnable;
   logic [AW-1:0] wrArray;
   logic [IW-1:0] wrIndex;
   logic [W-1:0]  wrData;
   logic          clrEnable;
   logic          wrReady;
   logic          start;
   logic [1:0]    mode;
   logic [AW-1:0] array;
   logic [W-1:0]  key;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          error;

   modport master (
      output wrEnable, wrArray, wrIndex, wrData, clrEnable,
      output start, mode, array, key,
      input  wrReady, busy, done, result, error
   );

   modport slave (
      input  wrEnable, wrArray, wrIndex, wrData, clrEnable,
      input  start, mode, array, key,
      output wrReady, busy, done, result, error
   );
endinterface

// File: rtl/array_heap.sv
// Element storage for all arrays plus the per-array fill size table.
// One write port (write or clear) and one combinational read port.
module array_heap
   import array_search_pkg::*;
#(
   parameter int W       = 12,
   parameter int NArea   = 3,
   parameter int NArrays = 1,
   parameter int AW      = 1,
   parameter int IW      = 2
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          we,
   input  logic          clr,
   input  logic [AW-1:0] wr_array,
   input  logic [IW-1:0] wr_index,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_array,
   input  logic [IW-1:0] rd_index,
   output logic [W-1:0]  rd_data,
   output logic [IW:0]   rd_size
);
   localparam int Depth = NArrays * NArea;
   localparam int HW    = width_of(Depth);

   logic [W-1:0]  mem_r [Depth];
   // Table is sized to the full array-select range so unused selects read as empty.
   logic [IW:0]   size_r [2**AW];
   logic [HW-1:0] wr_addr_s;
   logic [HW-1:0] rd_addr_s;
   logic [IW:0]   wr_len_s;
   logic [IW:0]   base_s;

   // Flat addressing and size forwarding so a same-cycle write is visible to a new search.
   always_comb begin
      wr_addr_s = HW'(wr_array) * HW'(NArea) + HW'(wr_index);
      rd_addr_s = HW'(rd_array) * HW'(NArea) + HW'(rd_index);
      wr_len_s  = {1'b0, wr_index} + (IW+1)'(1);
      base_s    = size_r[rd_array];
      rd_data   = mem_r[rd_addr_s];
      if (clr && (wr_array == rd_array)) begin
         rd_size = '0;
      end else if (we && (wr_array == rd_array) && (wr_len_s > base_s)) begin
         rd_size = wr_len_s;
      end else begin
         rd_size = base_s;
      end
   end

   // Heap words keep their contents through reset and clear.
   always_ff @(posedge clock) begin
      if (we) begin
         mem_r[wr_addr_s] <= wr_data;
      end
   end

   // Size table: reset and clear empty an array, writes grow it to the highest index written.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int a = 0; a < 2**AW; a++) begin
            size_r[a] <= '0;
         end
      end else if (clr) begin
         size_r[wr_array] <= '0;
      end else if (we && (wr_len_s > size_r[wr_array])) begin
         size_r[wr_array] <= wr_len_s;
      end
   end

endmodule

// File: rtl/array_search.sv
// Linear search engine over a small multi-array heap: finds the first match
// or counts elements less/greater/equal to a key, one element per cycle.
module array_search
   import array_search_pkg::*;
#(
   parameter int MemoryElementWidth = 12,
   parameter int NArea              = 3,
   parameter int NArrays            = 1
) (
   input  logic          clock,
   input  logic          reset,
   array_search_if.slave bus
);
   localparam int W  = MemoryElementWidth;
   localparam int AW = width_of(NArrays);
   localparam int IW = width_of(NArea);

   localparam logic [1:0]  IDLE = ST_IDLE;
   localparam logic [1:0]  SCAN = ST_SCAN;
   localparam logic [1:0]  DONE = ST_DONE;
   localparam logic [AW:0] NARRAYS_L = (AW+1)'(NArrays);
   localparam logic [IW:0] NAREA_L   = (IW+1)'(NArea);

   logic [1:0]    state_r, state_s;
   logic [IW-1:0] pos_r, pos_s;
   logic [IW:0]   last_r, last_s;
   logic [W-1:0]  cnt_r, cnt_s;
   logic [W-1:0]  result_r, result_s;
   logic [W-1:0]  key_r, key_s;
   logic [1:0]    mode_r, mode_s;
   logic [AW-1:0] array_r, array_s;
   logic          done_r, done_s;
   logic          error_r, error_s;
   logic          srch_err_r, srch_err_s;
   logic          ready_r, busy_r;

   logic          wr_ok_s, wr_bad_s, heap_we_s, heap_clr_s, arr_ok_s;
   logic          eq_s, hit_s;
   logic [W-1:0]  cnt_inc_s;
   logic [AW-1:0] rd_array_s;
   logic [W-1:0]  rd_data_s;
   logic [IW:0]   rd_size_s;

   array_heap #(
      .W       (W),
      .NArea   (NArea),
      .NArrays (NArrays),
      .AW      (AW),
      .IW      (IW)
   ) u_heap (
      .clock    (clock),
      .reset    (reset),
      .we       (heap_we_s),
      .clr      (heap_clr_s),
      .wr_array (bus.wrArray),
      .wr_index (bus.wrIndex),
      .wr_data  (bus.wrData),
      .rd_array (rd_array_s),
      .rd_index (pos_r),
      .rd_data  (rd_data_s),
      .rd_size  (rd_size_s)
   );

   // Write-side decode; clear wins over write and both need IDLE.
   always_comb begin
      wr_ok_s    = ({1'b0, bus.wrArray} < NARRAYS_L) && ({1'b0, bus.wrIndex} < NAREA_L);
      heap_clr_s = ready_r && bus.clrEnable && ({1'b0, bus.wrArray} < NARRAYS_L);
      heap_we_s  = ready_r && bus.wrEnable && !bus.clrEnable && wr_ok_s;
      wr_bad_s   = ready_r && bus.wrEnable && !bus.clrEnable && !wr_ok_s;
      arr_ok_s   = {1'b0, bus.array} < NARRAYS_L;
      rd_array_s = ready_r ? bus.array : array_r;
   end

   // Unsigned element/key comparison for the latched mode.
   always_comb begin
      eq_s = (rd_data_s == key_r);
      case (mode_r)
         MODE_LESS:    hit_s = (rd_data_s < key_r);
         MODE_GREATER: hit_s = (rd_data_s > key_r);
         MODE_EQUAL:   hit_s = eq_s;
         default:      hit_s = 1'b0;
      endcase
      cnt_inc_s = cnt_r + W'(hit_s);
   end

   // Next-state logic for the IDLE/SCAN/DONE sequencer.
   always_comb begin
      state_s    = state_r;
      pos_s      = pos_r;
      last_s     = last_r;
      cnt_s      = cnt_r;
      result_s   = result_r;
      key_s      = key_r;
      mode_s     = mode_r;
      array_s    = array_r;
      done_s     = 1'b0;
      error_s    = error_r;
      srch_err_s = srch_err_r;
      case (state_r)
         IDLE: begin
            error_s = wr_bad_s | srch_err_r;
            if (bus.start) begin
               key_s    = bus.key;
               mode_s   = bus.mode;
               array_s  = bus.array;
               pos_s    = '0;
               cnt_s    = '0;
               result_s = '0;
               last_s   = rd_size_s - (IW+1)'(1);
               if (!arr_ok_s) begin
                  state_s    = DONE;
                  done_s     = 1'b1;
                  srch_err_s = 1'b1;
                  error_s    = 1'b1;
               end else if (rd_size_s == '0) begin
                  state_s    = DONE;
                  done_s     = 1'b1;
                  srch_err_s = 1'b0;
                  error_s    = wr_bad_s;
               end else begin
                  state_s    = SCAN;
                  srch_err_s = 1'b0;
                  error_s    = wr_bad_s;
               end
            end else begin
               state_s = IDLE;
            end
         end
         SCAN: begin
            error_s = 1'b0;
            if (mode_r == MODE_INDEX) begin
               if (eq_s) begin
                  result_s = W'(pos_r) + W'(1);
                  state_s  = DONE;
                  done_s   = 1'b1;
               end else if ({1'b0, pos_r} == last_r) begin
                  result_s = '0;
                  state_s  = DONE;
                  done_s   = 1'b1;
               end else begin
                  pos_s = pos_r + IW'(1);
               end
            end else begin
               cnt_s = cnt_inc_s;
               if ({1'b0, pos_r} == last_r) begin
                  result_s = cnt_inc_s;
                  state_s  = DONE;
                  done_s   = 1'b1;
               end else begin
                  pos_s = pos_r + IW'(1);
               end
            end
         end
         DONE: begin
            state_s = IDLE;
            error_s = srch_err_r;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= IDLE;
         pos_r      <= '0;
         last_r     <= '0;
         cnt_r      <= '0;
         result_r   <= '0;
         key_r      <= '0;
         mode_r     <= 2'd0;
         array_r    <= '0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
         srch_err_r <= 1'b0;
         ready_r    <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         pos_r      <= pos_s;
         last_r     <= last_s;
         cnt_r      <= cnt_s;
         result_r   <= result_s;
         key_r      <= key_s;
         mode_r     <= mode_s;
         array_r    <= array_s;
         done_r     <= done_s;
         error_r    <= error_s;
         srch_err_r <= srch_err_s;
         ready_r    <= (state_s == IDLE);
         busy_r     <= (state_s != IDLE);
      end
   end

   assign bus.wrReady = ready_r;
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.result  = result_r;
   assign bus.error   = error_r;

endmodule

// File: tb/tb_array_search.sv
// Scenario bench for array_search (3 arrays of 3 x 12-bit elements):
// expected search outcomes are queued at start and compared at done.
module tb_array_search;
   import array_search_pkg::*;

   localparam int W    = 12;
   localparam int NAREA = 3;
   localparam int NARR = 3;
   localparam int AW   = 2;
   localparam int IW   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   array_search_if #(.W(W), .AW(AW), .IW(IW)) bus ();

   array_search #(
      .MemoryElementWidth (W),
      .NArea              (NAREA),
      .NArrays            (NARR)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [W-1:0] res;
      logic         err;
      int           edges;
      string        name;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic wr(input logic [AW-1:0] a, input logic [IW-1:0] i, input logic [W-1:0] d,
                     output logic err_o);
      @(negedge clk);
      bus.wrEnable = 1'b1; bus.wrArray = a; bus.wrIndex = i; bus.wrData = d;
      @(posedge clk); #1;
      bus.wrEnable = 1'b0;
      err_o = bus.error;
   endtask

   task automatic clr(input logic [AW-1:0] a);
      @(negedge clk);
      bus.clrEnable = 1'b1; bus.wrArray = a;
      @(posedge clk); #1;
      bus.clrEnable = 1'b0;
   endtask

   // Queues the expectation and presents start for exactly one sampling edge.
   task automatic start_search(input logic [1:0] m, input logic [AW-1:0] a, input logic [W-1:0] k,
                               input logic [W-1:0] er, input logic ee, input int eedges,
                               input string nm);
      exp_t e;
      e.res = er; e.err = ee; e.edges = eedges; e.name = nm;
      sb_q.push_back(e);
      @(negedge clk);
      bus.start = 1'b1; bus.mode = m; bus.array = a; bus.key = k;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Counts edges from the sampling edge to done, then samples one cycle later too.
   task automatic wait_done(output logic [W-1:0] r, output logic e, output int n, output bit to,
                            output logic d2, output logic rdy2, output logic [W-1:0] r2,
                            output logic e2);
      n = 1; to = 1'b0;
      while (bus.done !== 1'b1) begin
         if (n >= 40) begin
            to = 1'b1;
            break;
         end
         @(posedge clk); #1;
         n++;
      end
      r = bus.result; e = bus.error;
      @(posedge clk); #1;
      d2 = bus.done; rdy2 = bus.wrReady; r2 = bus.result; e2 = bus.error;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.done); end
      checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", bus.error); end
      checks++; if (bus.result !== 12'd0) begin failures++; $display("FAIL reset_result: got %0d want 0", bus.result); end
      checks++; if (bus.wrReady !== 1'b1) begin failures++; $display("FAIL reset_wrready: got %b want 1", bus.wrReady); end
   endtask

   task automatic test_write();
      logic [W-1:0] vals [3] = '{12'd10, 12'd20, 12'd30};
      logic err;
      for (int i = 0; i < 3; i++) begin
         wr(2'd0, IW'(i), vals[i], err);
         checks++;
         if (err !== 1'b0) begin failures++; $display("FAIL write_err idx%0d: got %b want 0", i, err); end
      end
   endtask

   task automatic test_index();
      logic [W-1:0] ky [2] = '{12'd20, 12'd40};
      logic [W-1:0] ex [2] = '{12'd2, 12'd0};
      int           ed [2] = '{3, 4};
      logic [W-1:0] r, r2; logic e, e2, d2, rdy2; int n; bit to; exp_t x;
      for (int t = 0; t < 2; t++) begin
         start_search(MODE_INDEX, 2'd0, ky[t], ex[t], 1'b0, ed[t], $sformatf("index_key%0d", ky[t]));
         wait_done(r, e, n, to, d2, rdy2, r2, e2);
         x = sb_q.pop_front();
         checks++;
         if (to || r !== x.res || e !== x.err || n !== x.edges || d2 !== 1'b0 || rdy2 !== 1'b1 || r2 !== x.res || e2 !== x.err) begin
            failures++;
            $display("FAIL %s: result=%0d error=%b edges=%0d timeout=%b done_next=%b ready_next=%b result_next=%0d; want result=%0d error=%b edges=%0d",
                     x.name, r, e, n, to, d2, rdy2, r2, x.res, x.err, x.edges);
         end
      end
   endtask

   task automatic test_count();
      logic [1:0]   md [3] = '{2'd1, 2'd2, 2'd3};
      logic [W-1:0] ky [3] = '{12'd25, 12'd10, 12'd20};
      logic [W-1:0] ex [3] = '{12'd2, 12'd2, 12'd1};
      logic [W-1:0] r, r2; logic e, e2, d2, rdy2; int n; bit to; exp_t x;
      for (int t = 0; t < 3; t++) begin
         start_search(md[t], 2'd0, ky[t], ex[t], 1'b0, 4, $sformatf("count_mode%0d", md[t]));
         wait_done(r, e, n, to, d2, rdy2, r2, e2);
         x = sb_q.pop_front();
         checks++;
         if (to || r !== x.res || e !== x.err || n !== x.edges || d2 !== 1'b0 || r2 !== x.res) begin
            failures++;
            $display("FAIL %s: result=%0d error=%b edges=%0d timeout=%b; want result=%0d error=%b edges=%0d",
                     x.name, r, e, n, to, x.res, x.err, x.edges);
         end
      end
   endtask

   task automatic test_clear();
      logic [W-1:0] r, r2; logic e, e2, d2, rdy2; int n; bit to; exp_t x;
      clr(2'd0);
      start_search(MODE_EQUAL, 2'd0, 12'd10, 12'd0, 1'b0, 1, "clear_empty");
      wait_done(r, e, n, to, d2, rdy2, r2, e2);
      x = sb_q.pop_front();
      checks++;
      if (to || r !== x.res || e !== x.err || n !== x.edges) begin
         failures++;
         $display("FAIL %s: result=%0d error=%b edges=%0d timeout=%b; want result=%0d error=%b edges=%0d",
                  x.name, r, e, n, to, x.res, x.err, x.edges);
      end
   endtask

   task automatic test_bad_write();
      logic [AW-1:0] ba [2] = '{2'd0, 2'd3};
      logic [IW-1:0] bi [2] = '{2'd3, 2'd0};
      logic [W-1:0]  va [3] = '{12'd10, 12'd20, 12'd30};
      logic [W-1:0] r, r2; logic e, e2, d2, rdy2, err; int n; bit to; exp_t x;
      for (int i = 0; i < 3; i++) wr(2'd0, IW'(i), va[i], err);
      for (int t = 0; t < 2; t++) begin
         wr(ba[t], bi[t], 12'd20, err);
         checks++;
         if (err !== 1'b1) begin failures++; $display("FAIL badwr_pulse%0d: got %b want 1", t, err); end
         @(posedge clk); #1;
         checks++;
         if (bus.error !== 1'b0) begin failures++; $display("FAIL badwr_end%0d: got %b want 0", t, bus.error); end
      end
      start_search(MODE_EQUAL, 2'd0, 12'd20, 12'd1, 1'b0, 4, "badwr_size0");
      wait_done(r, e, n, to, d2, rdy2, r2, e2);
      x = sb_q.pop_front();
      checks++;
      if (to || r !== x.res || e !== x.err || n !== x.edges) begin
         failures++;
         $display("FAIL %s: result=%0d error=%b edges=%0d timeout=%b; want result=%0d error=%b edges=%0d",
                  x.name, r, e, n, to, x.res, x.err, x.edges);
      end
      start_search(MODE_EQUAL, 2'd1, 12'd20, 12'd0, 1'b0, 1, "badwr_size1");
      wait_done(r, e, n, to, d2, rdy2, r2, e2);
      x = sb_q.pop_front();
      checks++;
      if (to || r !== x.res || e !== x.err || n !== x.edges) begin
         failures++;
         $display("FAIL %s: result=%0d error=%b edges=%0d timeout=%b; want result=%0d error=%b edges=%0d",
                  x.name, r, e, n, to, x.res, x.err, x.edges);
      end
   endtask

   task automatic test_bad_array();
      logic [W-1:0] r, r2; logic e, e2, d2, rdy2; int n; bit to; exp_t x;
      start_search(MODE_INDEX, 2'd3, 12'd10, 12'd0, 1'b1, 1, "bad_array");
      wait_done(r, e, n, to, d2, rdy2, r2, e2);
      x = sb_q.pop_front();
      checks++;
      if (to || r !== x.res || e !== x.err || n !== x.edges || e2 !== 1'b1 || rdy2 !== 1'b1) begin
         failures++;
         $display("FAIL %s: result=%0d error=%b edges=%0d timeout=%b error_next=%b; want result=%0d error=%b edges=%0d",
                  x.name, r, e, n, to, e2, x.res, x.err, x.edges);
      end
   endtask

   task automatic test_same_cycle();
      logic [W-1:0] r, r2; logic e, e2, d2, rdy2; int n; bit to; exp_t x;
      x.res = 12'd1; x.err = 1'b0; x.edges = 2; x.name = "same_cycle";
      sb_q.push_back(x);
      @(negedge clk);
      bus.wrEnable = 1'b1; bus.wrArray = 2'd1; bus.wrIndex = 2'd0; bus.wrData = 12'd55;
      bus.start = 1'b1; bus.mode = MODE_INDEX; bus.array = 2'd1; bus.key = 12'd55;
      @(posedge clk); #1;
      bus.wrEnable = 1'b0; bus.start = 1'b0;
      wait_done(r, e, n, to, d2, rdy2, r2, e2);
      x = sb_q.pop_front();
      checks++;
      if (to || r !== x.res || e !== x.err || n !== x.edges) begin
         failures++;
         $display("FAIL %s: result=%0d error=%b edges=%0d timeout=%b; want result=%0d error=%b edges=%0d",
                  x.name, r, e, n, to, x.res, x.err, x.edges);
      end
   endtask

   task automatic test_back_to_back_busy_write();
      logic [W-1:0] r, r2; logic e, e2, d2, rdy2; int n; bit to; exp_t x;
      for (int t = 0; t < 2; t++) begin
         start_search(MODE_LESS, 2'd0, 12'd25, 12'd2, 1'b0, 4, $sformatf("busy_write%0d", t));
         if (t == 0) begin
            fork
               wait_done(r, e, n, to, d2, rdy2, r2, e2);
               begin
                  @(negedge clk);
                  checks++;
                  if (bus.wrReady !== 1'b0) begin failures++; $display("FAIL busy_wrready: got %b want 0", bus.wrReady); end
                  bus.wrEnable = 1'b1; bus.wrArray = 2'd0; bus.wrIndex = 2'd2; bus.wrData = 12'd1;
                  @(negedge clk);
                  bus.wrEnable = 1'b0; bus.clrEnable = 1'b1;
                  @(negedge clk);
                  bus.clrEnable = 1'b0;
               end
            join
         end else begin
            wait_done(r, e, n, to, d2, rdy2, r2, e2);
         end
         x = sb_q.pop_front();
         checks++;
         if (to || r !== x.res || e !== x.err || n !== x.edges) begin
            failures++;
            $display("FAIL %s: result=%0d error=%b edges=%0d timeout=%b; want result=%0d error=%b edges=%0d",
                     x.name, r, e, n, to, x.res, x.err, x.edges);
         end
      end
   endtask

   task automatic test_reset_scan();
      bit seen_done = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.mode = MODE_GREATER; bus.array = 2'd0; bus.key = 12'd0;
      @(posedge clk); #1;
      bus.start = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 12'd0 || bus.wrReady !== 1'b1 || bus.error !== 1'b0) begin
         failures++;
         $display("FAIL reset_scan: busy=%b done=%b result=%0d wrReady=%b error=%b; want 0 0 0 1 0",
                  bus.busy, bus.done, bus.result, bus.wrReady, bus.error);
      end
      repeat (8) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) seen_done = 1'b1;
      end
      checks++;
      if (seen_done) begin failures++; $display("FAIL reset_no_done: done pulsed after reset, want none"); end
   endtask

   task automatic test_reset_retention();
      logic [W-1:0] ky [3] = '{12'd10, 12'd20, 12'd77};
      logic [1:0]   md [3] = '{2'd3, 2'd0, 2'd0};
      logic [W-1:0] ex [3] = '{12'd0, 12'd2, 12'd3};
      int           ed [3] = '{1, 3, 4};
      logic [W-1:0] r, r2; logic e, e2, d2, rdy2, err; int n; bit to; exp_t x;
      for (int t = 0; t < 3; t++) begin
         if (t == 1) wr(2'd0, 2'd2, 12'd77, err);
         start_search(md[t], 2'd0, ky[t], ex[t], 1'b0, ed[t], $sformatf("retain%0d", t));
         wait_done(r, e, n, to, d2, rdy2, r2, e2);
         x = sb_q.pop_front();
         checks++;
         if (to || r !== x.res || e !== x.err || n !== x.edges) begin
            failures++;
            $display("FAIL %s: result=%0d error=%b edges=%0d timeout=%b; want result=%0d error=%b edges=%0d",
                     x.name, r, e, n, to, x.res, x.err, x.edges);
         end
      end
   endtask

   initial begin
      bus.wrEnable = 1'b0; bus.wrArray = '0; bus.wrIndex = '0; bus.wrData = '0;
      bus.clrEnable = 1'b0; bus.start = 1'b0; bus.mode = 2'd0; bus.array = '0; bus.key = '0;
      test_reset();
      test_write();
      test_index();
      test_count();
      test_clear();
      test_bad_write();
      test_bad_array();
      test_same_cycle();
      test_back_to_back_busy_write();
      test_reset_scan();
      test_reset_retention();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
